// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Package  : fir_pkg
// Brief    : Shared sample width and sample type for the FIR delay line.
// Revision : 1.0 - initial release
// ============================================================================
package fir_pkg;

  localparam int SAMPLE_W = 24;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage : fir_pkg
`default_nettype wire

// File: rtl/en_dff_cell.sv
`default_nettype none
// ============================================================================
// Module   : en_dff_cell
// Brief    : 1-bit flop, async active-low reset, load enable, per-bit reset value.
// Revision : 1.0 - initial release
// ============================================================================
module en_dff_cell #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  input  logic i_d,
  output logic o_q
);

  logic r_q;
  logic w_next;

  // Enable is a data-path mux; the clock is never gated.
  assign w_next = i_en ? i_d : r_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q <= RST_VAL;
    end else begin
      r_q <= w_next;
    end
  end

  assign o_q = r_q;

endmodule : en_dff_cell
`default_nettype wire

// File: rtl/en_dff_bank.sv
`default_nettype none
// ============================================================================
// Module   : en_dff_bank
// Brief    : WIDTH-bit enabled register bank; one tap of the FIR delay line.
// Revision : 1.0 - initial release
// ============================================================================
module en_dff_bank
  import fir_pkg::*;
#(
  parameter int               WIDTH   = SAMPLE_W,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  // Each bit is an independent cell carrying its own slice of the reset value.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    en_dff_cell #(
      .RST_VAL (RST_VAL[i])
    ) u_cell (
      .clk   (clk),
      .reset (reset),
      .i_en  (en),
      .i_d   (D[i]),
      .o_q   (Q[i])
    );
  end

endmodule : en_dff_bank
`default_nettype wire

// File: tb/tb_en_dff_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_en_dff_bank
// Brief    : Self-checking bench for en_dff_bank, single bank plus 7-stage chain.
// Revision : 1.0 - initial release
// ============================================================================
module tb_en_dff_bank;

  localparam int          W      = 24;
  localparam int          STAGES = 7;
  localparam logic [23:0] RV     = 24'h5AC3A5;

  logic         clk   = 1'b0;
  logic         reset = 1'b1;
  logic         en    = 1'b0;
  logic [W-1:0] D     = 24'd20;
  logic [W-1:0] q_main;
  logic [W-1:0] q_rv;
  logic [W-1:0] cq [STAGES];

  int  n_cmp   = 0;
  int  n_fail  = 0;
  bit  started = 1'b0;

  // Most recent loads since the last reset, newest first.
  logic [W-1:0] hist[$];

  always #5 clk = ~clk;

  en_dff_bank dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .D     (D),
    .Q     (q_main)
  );

  en_dff_bank #(.WIDTH(W), .RST_VAL(RV)) dut_rv (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .D     (D),
    .Q     (q_rv)
  );

  for (genvar j = 0; j < STAGES; j++) begin : g_chain
    if (j == 0) begin : g_first
      en_dff_bank u_bank (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .D     (D),
        .Q     (cq[0])
      );
    end else begin : g_rest
      en_dff_bank u_bank (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .D     (cq[j-1]),
        .Q     (cq[j])
      );
    end
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist.delete();
    end else if (en) begin
      hist.push_front(D);
      if (hist.size() > STAGES + 1) void'(hist.pop_back());
    end
  end

  function automatic logic [W-1:0] expect_at(int k, logic [W-1:0] rst_val);
    if (hist.size() > k) return hist[k];
    return rst_val;
  endfunction

  task automatic check(string name, logic [W-1:0] act, logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      check("model_main", q_main, expect_at(0, '0));
      check("model_rstval", q_rv, expect_at(0, RV));
      for (int k = 0; k < STAGES; k++)
        check($sformatf("model_stage%0d", k), cq[k], expect_at(k, '0));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(logic e, logic [W-1:0] d);
    en = e;
    D  = d;
  endtask

  logic [W-1:0] samp [8];
  logic [W-1:0] pat;

  initial begin
    #1 reset = 1'b0;
    started = 1'b1;
    #2 check("reset_async", q_main, 24'd0);
    check("reset_async_rv", q_rv, RV);
    tick();
    check("reset_held", q_main, 24'd0);
    reset = 1'b1;

    drive(1'b0, 24'd20); tick(); tick();
    check("hold_en0", q_main, 24'd0);
    drive(1'b1, 24'd20); tick();
    check("load_20", q_main, 24'd20);
    drive(1'b0, 24'd40); tick();
    check("gate_40", q_main, 24'd20);
    drive(1'b1, 24'd40); tick();
    check("load_40", q_main, 24'd40);
    drive(1'b0, 24'd10); tick();
    check("gate_10", q_main, 24'd40);

    drive(1'b1, 24'd60);  tick(); check("b2b_60", q_main, 24'd60);
    drive(1'b1, 24'd80);  tick(); check("b2b_80", q_main, 24'd80);
    drive(1'b1, 24'd100); tick(); check("b2b_100", q_main, 24'd100);

    drive(1'b1, 24'hFFFFEC); tick(); check("neg_20", q_main, 24'hFFFFEC);
    drive(1'b1, 24'h800000); tick(); check("min_neg", q_main, 24'h800000);
    drive(1'b1, 24'h7FFFFF); tick(); check("max_pos", q_main, 24'h7FFFFF);

    for (int i = 0; i < W; i++) begin
      pat = 24'd1 << i;
      drive(1'b1, pat); tick();
      check($sformatf("walk1_bit%0d", i), q_main, pat);
    end

    drive(1'b1, 24'd120); tick();
    check("pre_rst_120", q_main, 24'd120);
    en = 1'b0;
    #1 reset = 1'b0;
    #1 check("mid_rst_clear", q_main, 24'd0);
    check("mid_rst_clear_rv", q_rv, RV);
    drive(1'b1, 24'd60); tick();
    check("rst_beats_en", q_main, 24'd0);
    reset = 1'b1;
    drive(1'b1, 24'd10); tick();
    check("post_rst_10", q_main, 24'd10);
    check("post_rst_rv_10", q_rv, 24'd10);

    // Eight en pulses separated by idle cycles; stage k must hold load 7-k.
    for (int s = 0; s < 8; s++) begin
      samp[s] = 24'h100000 + 24'(s * 24'h011111);
      drive(1'b1, samp[s]); tick();
      drive(1'b0, 24'hABCDEF); tick();
    end
    for (int k = 0; k < STAGES; k++)
      check($sformatf("chain_stage%0d", k), cq[k], samp[7-k]);

    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 39) == 0) begin
        #1 reset = 1'b0;
        #3 reset = 1'b1;
      end else if ($urandom_range(0, 59) == 0) begin
        reset = 1'b0;
      end else begin
        reset = 1'b1;
      end
      drive(1'($urandom_range(0, 1)), 24'($urandom));
      tick();
    end
    reset = 1'b1;
    drive(1'b0, 24'd0);
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_en_dff_bank
`default_nettype wire
